// File: rtl/fp_seq_pkg.sv
// Shared types and defaults for the floating-point adder sequencer.
package fp_seq_pkg;

  localparam int unsigned STATE_W             = 3;
  localparam int unsigned STATE_COUNT         = 8;
  localparam int unsigned ALIGN_LIMIT_DEFAULT = 31;
  localparam int unsigned WD_W_DEFAULT        = 6;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SETUP = 3'd2,
    ALIGN = 3'd3,
    SUM   = 3'd4,
    FMLD  = 3'd5,
    NORM  = 3'd6,
    DONE  = 3'd7
  } seqStateT;

endpackage

// File: rtl/fp_seq_watchdog.sv
// ALIGN-phase cycle counter; flags when the alignment has run ALIGN_LIMIT cycles.
module fp_seq_watchdog #(
  parameter int unsigned ALIGN_LIMIT = 31,
  parameter int unsigned WD_W        = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [WD_W-1:0] wdCnt;

  // Holds at the limit so a stalled FSM can never wrap the count.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wdCnt <= '0;
    end else if (inc && !expired) begin
      wdCnt <= wdCnt + WD_W'(1);
    end
  end

  assign expired = (wdCnt == WD_W'(ALIGN_LIMIT));

endmodule

// File: rtl/fp_add_sequencer.sv
// Control FSM stepping the FP adder datapath through one addition per start.
// Optional ALIGN watchdog and err flag built when FP_SEQ_WATCHDOG_EN is defined.
module fp_add_sequencer
  import fp_seq_pkg::*;
#(
  parameter int unsigned ALIGN_LIMIT = ALIGN_LIMIT_DEFAULT,
  parameter int unsigned WD_W        = WD_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic complete,
  input  logic OV,
  output logic busy,
  output logic done,
  output logic err,
  output logic ldS1,
  output logic ldS2,
  output logic ldExp1,
  output logic ldExp2,
  output logic ldM1,
  output logic ldM2,
  output logic ldRegA,
  output logic ldRegB,
  output logic ldC,
  output logic shEn,
  output logic cntEn,
  output logic ldRegS,
  output logic ldFM,
  output logic shM
);

  seqStateT state;
  seqStateT nextState;
  logic     ovQ;
  logic     wdExpired;

`ifdef FP_SEQ_WATCHDOG_EN
  logic errQ;

  fp_seq_watchdog #(
    .ALIGN_LIMIT(ALIGN_LIMIT),
    .WD_W       (WD_W)
  ) uWatchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == SETUP),
    .inc    (state == ALIGN),
    .expired(wdExpired)
  );

  // Sticky abort flag: raised on a watchdog exit, cleared by the next operand load.
  always_ff @(posedge clk) begin
    if (rst || state == LOAD) begin
      errQ <= 1'b0;
    end else if (state == ALIGN && !complete && wdExpired) begin
      errQ <= 1'b1;
    end
  end

  assign err = errQ && (state inside {SUM, FMLD, NORM, DONE});
`else
  logic [1:0] unusedCfg;

  assign wdExpired = 1'b0;
  assign err       = 1'b0;
  assign unusedCfg = {ALIGN_LIMIT[0], WD_W[0]};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ovQ   <= 1'b0;
    end else begin
      state <= nextState;
      if (state == FMLD) begin
        ovQ <= OV;
      end
    end
  end

  always_comb begin
    nextState = state;
    busy      = (state != IDLE);
    done      = 1'b0;
    ldS1      = 1'b0;
    ldS2      = 1'b0;
    ldExp1    = 1'b0;
    ldExp2    = 1'b0;
    ldM1      = 1'b0;
    ldM2      = 1'b0;
    ldRegA    = 1'b0;
    ldRegB    = 1'b0;
    ldC       = 1'b0;
    shEn      = 1'b0;
    cntEn     = 1'b0;
    ldRegS    = 1'b0;
    ldFM      = 1'b0;
    shM       = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          nextState = LOAD;
        end
      end
      LOAD: begin
        ldS1      = 1'b1;
        ldS2      = 1'b1;
        ldExp1    = 1'b1;
        ldExp2    = 1'b1;
        ldM1      = 1'b1;
        ldM2      = 1'b1;
        nextState = SETUP;
      end
      SETUP: begin
        ldRegA    = 1'b1;
        ldRegB    = 1'b1;
        ldC       = 1'b1;
        nextState = ALIGN;
      end
      // Shift/decrement until the datapath counter expires or the watchdog trips.
      ALIGN: begin
        if (complete || wdExpired) begin
          nextState = SUM;
        end else begin
          shEn  = 1'b1;
          cntEn = 1'b1;
        end
      end
      SUM: begin
        ldRegS    = 1'b1;
        nextState = FMLD;
      end
      FMLD: begin
        ldFM      = 1'b1;
        nextState = OV ? NORM : DONE;
      end
      NORM: begin
        shM       = ovQ;
        nextState = DONE;
      end
      DONE: begin
        done      = 1'b1;
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Scoreboard bench for fp_add_sequencer with a behavioural alignment-counter model.
module tb_fp_add_sequencer;

  logic clk = 1'b0;
  logic rst, start, complete, OV;
  logic busy, done, err;
  logic ldS1, ldS2, ldExp1, ldExp2, ldM1, ldM2;
  logic ldRegA, ldRegB, ldC, shEn, cntEn, ldRegS, ldFM, shM;

  fp_add_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .complete(complete), .OV(OV),
    .busy(busy), .done(done), .err(err),
    .ldS1(ldS1), .ldS2(ldS2), .ldExp1(ldExp1), .ldExp2(ldExp2), .ldM1(ldM1), .ldM2(ldM2),
    .ldRegA(ldRegA), .ldRegB(ldRegB), .ldC(ldC), .shEn(shEn), .cntEn(cntEn),
    .ldRegS(ldRegS), .ldFM(ldFM), .shM(shM)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lat;
    int shifts;
    int shm;
    int err;
    bit chkGap;
  } expT;

  expT expQ[$];

  int  checks = 0;
  int  errors = 0;
  int  edgeCnt = 0;
  int  curD = 0;
  bit  curOv = 1'b0;
  bit  stuck = 1'b0;
  int  dpCnt = 0;
  int  idleReq = 0;
  int  idleAck = 0;
  bit  finReq = 1'b0;
  bit  finAck = 1'b0;

  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  // Datapath alignment counter: loaded with d on ldC, decremented on cntEn.
  always @(posedge clk) begin
    if (ldC) dpCnt <= curD;
    else if (cntEn) dpCnt <= dpCnt - 1;
  end
  assign complete = stuck ? 1'b0 : (dpCnt == 0);
  assign OV = curOv;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor
  bit inOp = 1'b0;
  int loadEdge = 0, lastDone = -100, gap = 0, shifts = 0, shm = 0;
  bit viol = 1'b0;

  always @(negedge clk) begin
    logic [5:0] ops;
    logic [2:0] setg;
    int groups;
    expT e;
    ops    = {ldS1, ldS2, ldExp1, ldExp2, ldM1, ldM2};
    setg   = {ldRegA, ldRegB, ldC};
    groups = int'(|ops) + int'(|setg) + int'(shEn | cntEn) + int'(ldRegS) + int'(ldFM)
           + int'(shM) + int'(done);
    if (rst) begin
      inOp = 1'b0;
    end else begin
      if (idleReq != idleAck) begin
        idleAck = idleReq;
        chk("idle_busy", int'(busy), 0);
        chk("idle_outputs", groups + int'(err), 0);
      end
      if (ldS1) begin
        inOp = 1'b1;
        loadEdge = edgeCnt;
        gap = edgeCnt - lastDone;
        shifts = 0;
        shm = 0;
        viol = 1'b0;
      end
      if (inOp) begin
        if (shEn) shifts++;
        if (shM) shm++;
        if (groups > 1 || (|ops && !(&ops)) || (|setg && !(&setg)) || shEn != cntEn)
          viol = 1'b1;
      end
      if (!busy && (groups != 0 || err)) viol = 1'b1;
      if (done) begin
        if (expQ.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = expQ.pop_front();
          chk("latency", edgeCnt - loadEdge, e.lat);
          chk("shift_cycles", shifts, e.shifts);
          chk("shM_cycles", shm, e.shm);
          chk("err_with_done", int'(err), e.err);
          chk("strobe_exclusive", int'(viol), 0);
          if (e.chkGap) chk("idle_gap", gap, 2);
        end
        lastDone = edgeCnt;
        inOp = 1'b0;
      end
      if (inOp && (edgeCnt - loadEdge) > 100) begin
        chk("op_timeout", edgeCnt - loadEdge, 100);
        inOp = 1'b0;
      end
    end
    if (finReq && !finAck) begin
      finAck = 1'b1;
      chk("pending_expect", expQ.size(), 0);
    end
  end

  task automatic push(input int lat, input int sh, input int sm, input int er, input bit g);
    expT e;
    e.lat = lat; e.shifts = sh; e.shm = sm; e.err = er; e.chkGap = g;
    expQ.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && expQ.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic idleCheck();
    idleReq++;
    repeat (2) @(negedge clk);
  endtask

  task automatic runOp(input int d, input bit ov, input int lat, input int sh, input int sm,
                       input int er);
    curD = d;
    curOv = ov;
    push(lat, sh, sm, er, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
  endtask

  initial begin
    int loads;
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    idleCheck();

    // d=3, OV=0, with a stray start pulse mid-ALIGN that must not queue.
    curD = 3; curOv = 1'b0;
    push(8, 3, 0, 0, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    idleCheck();

    // d=0 with overflow normalisation.
    runOp(0, 1'b1, 6, 0, 1, 0);

    // Start held high: back-to-back ops, d=1, OV=1.
    curD = 1; curOv = 1'b1;
    push(7, 1, 1, 0, 1'b0);
    push(7, 1, 1, 0, 1'b1);
    push(7, 1, 1, 0, 1'b1);
    start = 1'b1;
    loads = 0;
    for (int i = 0; i < 100 && loads < 3; i++) begin
      @(negedge clk);
      if (ldS1) loads++;
    end
    start = 1'b0;
    drain();

    // Reset during ALIGN aborts; next op runs normally.
    curD = 5; curOv = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idleCheck();
    repeat (3) @(negedge clk);
    runOp(2, 1'b0, 7, 2, 0, 0);

`ifdef FP_SEQ_WATCHDOG_EN
    stuck = 1'b1;
    runOp(40, 1'b0, 36, 31, 0, 1);
    stuck = 1'b0;
    runOp(2, 1'b1, 8, 2, 1, 0);
`endif

    finReq = 1'b1;
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
